// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter that shares one floating-point adder among four requesters,
// with a guard against stale adder completions and a timeout that returns a quiet NaN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | offering the round-robin grant; accept captures operands
// S_START | one-cycle start pulse to the shared adder, counter cleared
// S_WAIT  | waiting for add_done (ignored on first cycle) or timeout
// S_RESP  | one-cycle response to the granted requester
module fpadd_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req_valid,
    input  logic [127:0] req_a,
    input  logic [127:0] req_b,
    output logic [3:0]   req_ready,
    output logic [3:0]   resp_valid,
    output logic [31:0]  resp_sum,
    output logic         resp_err,
    output logic         add_start,
    output logic [31:0]  add_a,
    output logic [31:0]  add_b,
    input  logic [31:0]  add_sum,
    input  logic         add_done,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] sum_q, sum_d;
    logic        err_q, err_d;

    logic [1:0]  gnt_idx;
    logic        gnt_any;
    logic [1:0]  cand;
    logic        accept;
    logic        done_ok;

    // Walk from farthest to nearest offset so the requester right after ptr_q wins.
    always_comb begin
        gnt_idx = ptr_q;
        gnt_any = 1'b0;
        cand    = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr_q + 2'(k);
            if (req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign accept    = (state_q == S_IDLE) && !reset && gnt_any;
    assign req_ready = accept ? 4'(4'b0001 << gnt_idx) : 4'b0000;
    assign done_ok   = add_done && (cnt_q != 8'd0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = req_a[{gnt_idx, 5'b0} +: 32];
                    b_d     = req_b[{gnt_idx, 5'b0} +: 32];
                    idx_d   = gnt_idx;
                    ptr_d   = gnt_idx;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A qualifying done takes precedence over the timeout limit.
                if (done_ok) begin
                    sum_d   = add_sum;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    sum_d   = QNAN;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd3;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sum_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = (state_q == S_RESP) ? 4'(4'b0001 << idx_q) : 4'b0000;
    assign resp_sum   = sum_q;
    assign resp_err   = err_q;
    assign add_start  = (state_q == S_START);
    assign add_a      = a_q;
    assign add_b      = b_q;
    assign busy       = (state_q != S_IDLE);

endmodule
